// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the datapath and its control unit.
// Bus source codes, strobe bit indices and ALU op codes.
package cpu_pkg;

  localparam logic [3:0] SEL_NONE = 4'd0;
  localparam logic [3:0] SEL_PC   = 4'd1;
  localparam logic [3:0] SEL_AR   = 4'd2;
  localparam logic [3:0] SEL_DR   = 4'd3;
  localparam logic [3:0] SEL_IR   = 4'd4;
  localparam logic [3:0] SEL_AC   = 4'd5;
  localparam logic [3:0] SEL_R    = 4'd6;
  localparam logic [3:0] SEL_R1   = 4'd7;
  localparam logic [3:0] SEL_R2   = 4'd8;
  localparam logic [3:0] SEL_R3   = 4'd9;
  localparam logic [3:0] SEL_R4   = 4'd10;
  localparam logic [3:0] SEL_R5   = 4'd11;
  localparam logic [3:0] SEL_DM   = 4'd12;
  localparam logic [3:0] SEL_IM   = 4'd13;
  localparam logic [3:0] SEL_AC2  = 4'd14;

  localparam int B_PC  = 1;
  localparam int B_AR  = 2;
  localparam int B_IR  = 3;
  localparam int B_AC  = 4;
  localparam int B_R   = 5;
  localparam int B_R5  = 6;
  localparam int B_R4  = 7;
  localparam int B_R3  = 8;
  localparam int B_R2  = 9;
  localparam int B_R1  = 10;
  localparam int B_DM  = 11;
  localparam int B_ALU = 12;

  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_MUL = 3'd3;
  localparam logic [2:0] ALU_LSH = 3'd4;

endpackage

// File: rtl/datapath_alu.sv
// datapath_alu: combinational ALU, operands AC and R.
// Ports: ac, r, alu_op in; result out (AC itself for no-op codes).
module datapath_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] ac,
  input  logic [DATA_W-1:0] r,
  input  logic [2:0]        alu_op,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = ac;
    case (alu_op)
      ALU_ADD: result = ac + r;
      ALU_SUB: result = ac - r;
      ALU_MUL: result = ac * r;
      ALU_LSH: result = ac << 1;
      default: result = ac;
    endcase
  end

endmodule

// File: rtl/datapath_bus.sv
// datapath_bus: register bank, shared bus mux and ALU hookup.
// Ports: strobes/alu_op/memory data in; bus, memory ports, instruction, z out.
module datapath_bus
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        read_en,
  input  logic [15:0]       write_en,
  input  logic [15:0]       inc_en,
  input  logic [15:0]       clr_en,
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] im_rdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [DATA_W-1:0] im_addr,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  output logic [DATA_W-1:0] bus,
  output logic [OPC_W-1:0]  instruction,
  output logic [15:0]       z,
  output logic [DATA_W-1:0] ac_out
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic [DATA_W-1:0] r_pc, r_ar, r_dr, r_ir, r_ac, r_r;
  logic [DATA_W-1:0] r_r1, r_r2, r_r3, r_r4, r_r5;
  logic [DATA_W-1:0] w_bus, w_alu;
  logic              w_unused;

  assign w_unused = ^{write_en[0], write_en[15:13],
                      inc_en[0], inc_en[3:2], inc_en[15:5],
                      clr_en[0], clr_en[15:11]};

  always_comb begin
    w_bus = '0;
    case (read_en)
      SEL_PC:  w_bus = r_pc;
      SEL_AR:  w_bus = r_ar;
      SEL_DR:  w_bus = r_dr;
      SEL_IR:  w_bus = r_ir;
      SEL_AC:  w_bus = r_ac;
      SEL_R:   w_bus = r_r;
      SEL_R1:  w_bus = r_r1;
      SEL_R2:  w_bus = r_r2;
      SEL_R3:  w_bus = r_r3;
      SEL_R4:  w_bus = r_r4;
      SEL_R5:  w_bus = r_r5;
      SEL_DM:  w_bus = dm_rdata;
      SEL_IM:  w_bus = im_rdata;
      SEL_AC2: w_bus = r_ac;
      default: w_bus = '0;
    endcase
  end

  datapath_alu #(.DATA_W(DATA_W)) u_alu (
    .ac     (r_ac),
    .r      (r_r),
    .alu_op (alu_op),
    .result (w_alu)
  );

  // PC and AC are the only incrementable registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_pc <= '0;
    else if (clr_en[B_PC])    r_pc <= '0;
    else if (write_en[B_PC])  r_pc <= w_bus;
    else if (inc_en[B_PC])    r_pc <= r_pc + ONE;
  end

  // ALU no-op codes return AC, so write_en[ALU] then holds AC
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_ac <= '0;
    else if (clr_en[B_AC])    r_ac <= '0;
    else if (write_en[B_ALU]) r_ac <= w_alu;
    else if (write_en[B_AC])  r_ac <= w_bus;
    else if (inc_en[B_AC])    r_ac <= r_ac + ONE;
  end

  // DR captures memory data whenever it is put on the bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_dr <= '0;
    else if (read_en == SEL_DM) r_dr <= dm_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ar <= '0; r_ir <= '0; r_r <= '0;
      r_r1 <= '0; r_r2 <= '0; r_r3 <= '0;
      r_r4 <= '0; r_r5 <= '0;
    end else begin
      if (clr_en[B_AR])       r_ar <= '0;
      else if (write_en[B_AR]) r_ar <= w_bus;
      if (clr_en[B_IR])       r_ir <= '0;
      else if (write_en[B_IR]) r_ir <= w_bus;
      if (clr_en[B_R])        r_r <= '0;
      else if (write_en[B_R])  r_r <= w_bus;
      if (clr_en[B_R1])       r_r1 <= '0;
      else if (write_en[B_R1]) r_r1 <= w_bus;
      if (clr_en[B_R2])       r_r2 <= '0;
      else if (write_en[B_R2]) r_r2 <= w_bus;
      if (clr_en[B_R3])       r_r3 <= '0;
      else if (write_en[B_R3]) r_r3 <= w_bus;
      if (clr_en[B_R4])       r_r4 <= '0;
      else if (write_en[B_R4]) r_r4 <= w_bus;
      if (clr_en[B_R5])       r_r5 <= '0;
      else if (write_en[B_R5]) r_r5 <= w_bus;
    end
  end

  assign bus         = w_bus;
  assign im_addr     = r_pc;
  assign dm_addr     = r_ar;
  assign dm_wdata    = w_bus;
  assign dm_we       = write_en[B_DM];
  assign instruction = r_ir[OPC_W-1:0];
  assign z           = {15'd0, (r_ac == '0)};
  assign ac_out      = r_ac;

endmodule

// File: doc/datapath_bus.md
Name: datapath_bus

Overview:
- Datapath-side responder to the microcoded control FSM.
- Decodes `read_en` into a single shared-bus source. Applies `write_en`, `inc_en` and `clr_en` to the register bank (PC, AR, DR, IR, AC, R, R1–R5). Executes ALU ops into AC.
- Returns `instruction` and `z` to the control unit and drives the IM/DM memory ports.
- Registers update on `clk` rising edge. The control unit changes state on the falling edge, so its outputs are stable at every rising edge.

Parameters:
- `DATA_W`, 16, width of the bus and of every register.
- `OPC_W`, 6, width of the opcode field taken from IR[OPC_W-1:0].

Ports:
- `clk`  in  1  system clock, rising-edge active.
- `rst`  in  1  asynchronous, active-high reset.
- `read_en`  in  4  bus source select code.
- `write_en`  in  16  one-hot-per-bit load strobes.
- `inc_en`  in  16  increment strobes.
- `clr_en`  in  16  clear strobes.
- `alu_op`  in  3  ALU operation select.
- `im_rdata`  in  DATA_W  instruction memory read data.
- `dm_rdata`  in  DATA_W  data memory read data.
- `im_addr`  out  DATA_W  equals PC.
- `dm_addr`  out  DATA_W  equals AR.
- `dm_wdata`  out  DATA_W  equals bus.
- `dm_we`  out  1  equals write_en[11].
- `bus`  out  DATA_W  shared bus value (observability).
- `instruction`  out  OPC_W  equals IR[OPC_W-1:0].
- `z`  out  16  16'd1 when AC==0, else 16'd0.
- `ac_out`  out  DATA_W  AC value (debug).

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset: PC, AR, DR, IR, AC, R, R1–R5 all go to 0.
  - Consequence: instruction=0, z=16'd1, im_addr=0, dm_addr=0.
  - bus=0 while read_en=0; dm_we follows write_en[11] combinationally.
- Bus mux (combinational), read_en code → source:
  - 0: zero. 1: PC. 2: AR. 3: DR. 4: IR. 5: AC. 6: R.
  - 7: R1. 8: R2. 9: R3. 10: R4. 11: R5.
  - 12: dm_rdata. 13: im_rdata. 14: AC. 15: zero.
- write_en bit → destination register:
  - 1 PC, 2 AR, 3 IR, 4 AC, 5 R, 6 R5, 7 R4, 8 R3, 9 R2, 10 R1.
  - 11 is the DM write strobe; no register is loaded.
  - 12 is ALU→AC.
  - Bits 0, 13, 14, 15 are ignored.
  - DR loads from dm_rdata whenever read_en==12 (memory data register capture).
- inc_en / clr_en use the same bit positions as write_en. Increment is implemented for PC (bit 1) and AC (bit 4); other bits are ignored.
- Per-register priority on a rising edge, highest first:
  - clr → 0.
  - AC only: ALU result (write_en[12]).
  - write → bus.
  - inc → +1.
  - Otherwise hold.
- Increment wraps: 16'hFFFF + 1 = 0.
- ALU operands are AC and R. Results are truncated to DATA_W.
  - 1 add.
  - 2 sub (AC−R, two's complement wrap).
  - 3 mult (low DATA_W bits of AC*R).
  - 4 lshift (AC<<1, LSB=0).
  - 0, 5, 6, 7: AC unchanged, even with write_en[12] set.
- Latency:
  - Register loads take one edge; the new value is visible on `bus` and the outputs right after that edge.
  - z is combinational from the AC register, so it is valid in the same cycle AC changes.
- Simultaneous strobes:
  - Several write_en bits set at once load every selected register from the same bus value.
  - A register that is both the bus source and a destination loads its own old value.
- Reset mid-operation: asserting `rst` clears all registers immediately, regardless of clk. Deassertion takes effect at the next rising edge.
- Fetch sequence: fetch1 puts IM on the bus and loads IR; fetch2 repeats that and increments PC.
  - Since IR loads from im_rdata at the PC value sampled before the increment, both edges load the same word.

Decomposition:
- Shared package `cpu_pkg`:
  - read_en code constants (SEL_NONE..SEL_IM).
  - write/inc/clr bit-index constants (B_PC, B_AR, B_IR, B_AC, B_R, B_R1..B_R5, B_DM, B_ALU).
  - ALU op constants (ALU_NOP, ALU_ADD, ALU_SUB, ALU_MUL, ALU_LSH).
- Sub-module `datapath_alu`: purely combinational `(ac, r, alu_op) -> result`. It is instantiated once.
- Everything else lives in `datapath_bus`.

Test Plan:
- Reset: pulse rst asynchronously between edges → all registers 0, z=16'd1, instruction=0, bus=0.
- Fetch: im_rdata=16'h0003; read_en=13, write_en[3] for one edge, then read_en=13, write_en[3]+inc_en[1] for one edge → IR=0003, instruction=6'd3, PC=1.
- Load/add: dm_rdata=16'd7, read_en=12, write_en[4] → AC=7, DR=7, z=0. Then read_en=5, write_en[5] → R=7. Then write_en[12], alu_op=1 → AC=14.
- Wrap and priority:
  - AC=16'hFFFF with inc_en[4] → AC=0, z=1.
  - clr_en[4]+write_en[4]+inc_en[4] together → AC=0.
  - write_en[12], alu_op=0 → AC unchanged.
- Store: AR=16'h0020, AC=16'h00AB, read_en=5, write_en[11] → dm_we=1, dm_addr=0020, dm_wdata=00AB for exactly that cycle; no register changes.
- Mul/shift/sub:
  - AC=16'h0100, R=16'h0100, alu_op=3 → AC=0.
  - AC=16'h8001, alu_op=4 → AC=16'h0002.
  - AC=3, R=5, alu_op=2 → AC=16'hFFFE.
